// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: fetch FSM state encodings and shared constants
package instruction_fetch_pkg;
  typedef enum logic [2:0] {
    FETCH_IDLE  = 3'd0,
    FETCH_REQ   = 3'd1,
    FETCH_HOLD  = 3'd2,
    FETCH_DRAIN = 3'd3,
    FETCH_FAULT = 3'd4
  } fetch_state_e;
  localparam logic [1:0] INSTR_ALIGN_MASK = 2'b11;
  localparam int RISCV_INSTR_WIDTH = 32;
endpackage

// File: rtl/instruction_fetch_watchdog.sv
// instruction_fetch_watchdog: clearable counter flagging a memory response that never arrives
module instruction_fetch_watchdog #(
  parameter int timeout_cycles = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(timeout_cycles);
  logic [W-1:0] count;
  assign expired = count == W'(timeout_cycles - 1);
  // count waiting cycles, saturating at the expiry value
  always_ff @(posedge clk) begin
    if (rst || clear) count <= '0;
    else if (enable && !expired) count <= count + 1'b1;
  end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetches one word per pc over req/rvalid and hands it to decode
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int addr_size      = 32,
  parameter int instr_size     = RISCV_INSTR_WIDTH,
  parameter int timeout_cycles = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [addr_size-1:0]  pc,
  output logic                  pc_latch,
  output logic                  mem_req,
  output logic [addr_size-1:0]  mem_addr,
  input  logic [instr_size-1:0] mem_rdata,
  input  logic                  mem_rvalid,
  input  logic                  flush,
  output logic [instr_size-1:0] instr,
  output logic [addr_size-1:0]  instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic                  fault
);
  fetch_state_e state, state_next;
  logic expired;
  logic waiting;
  assign waiting = state == FETCH_REQ || state == FETCH_DRAIN;
  assign mem_req = waiting;
  instruction_fetch_watchdog #(.timeout_cycles(timeout_cycles)) u_watchdog (
    .clk(clk),
    .rst(rst),
    .clear(state == FETCH_IDLE),
    .enable(waiting && !mem_rvalid),
    .expired(expired)
  );
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH_IDLE;
    else state <= state_next;
  end
  // next state and the pc advance pulse; flush always wins over a decode accept
  always_comb begin
    state_next = state;
    pc_latch = state == FETCH_HOLD && instr_ready && !flush;
    case (state)
      FETCH_IDLE:  state_next = |(pc[1:0] & INSTR_ALIGN_MASK) ? FETCH_FAULT : FETCH_REQ;
      FETCH_REQ:   state_next = flush ? (mem_rvalid ? FETCH_IDLE : FETCH_DRAIN)
                              : mem_rvalid ? FETCH_HOLD : expired ? FETCH_FAULT : FETCH_REQ;
      FETCH_HOLD:  state_next = flush || instr_ready ? FETCH_IDLE : FETCH_HOLD;
      FETCH_DRAIN: state_next = mem_rvalid ? FETCH_IDLE : expired ? FETCH_FAULT : FETCH_DRAIN;
      FETCH_FAULT: state_next = FETCH_FAULT;
      default:     state_next = FETCH_IDLE;
    endcase
  end
  // address capture, response capture and registered status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr <= '0;
      instr <= '0;
      instr_pc <= '0;
      instr_valid <= 1'b0;
      fault <= 1'b0;
    end else begin
      if (state == FETCH_IDLE) mem_addr <= pc;
      if (state == FETCH_REQ && mem_rvalid && !flush) begin
        instr <= mem_rdata;
        instr_pc <= mem_addr;
      end
      instr_valid <= state_next == FETCH_HOLD;
      fault <= state_next == FETCH_FAULT;
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed and randomized checks of fetch against a pc/memory model
module tb_instruction_fetch;
  logic clk = 0, rst = 1;
  logic [31:0] pc;
  logic pc_latch, mem_req, instr_valid, fault;
  logic [31:0] mem_addr, instr, instr_pc;
  logic [31:0] mem_rdata = 0;
  logic mem_rvalid = 0, flush = 0, instr_ready = 0;
  int tests = 0, failed = 0;
  logic [63:0] acc_q[$];
  int latch_cnt = 0, acc_total = 0, mem_lat = 0, wait_cnt = 0, cnt;
  logic [31:0] model_pc = 0, force_val = 0, p, v, ip;
  bit mem_on = 1, force_rv = 0, force_en = 0;

  instruction_fetch dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_latch(pc_latch), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .flush(flush), .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .fault(fault)
  );

  always #5 clk = ~clk;

  // program counter: +4 on each latch pulse, optionally forced to a branch target
  always @(posedge clk) begin
    if (force_en) pc <= force_val;
    else if (rst) pc <= 0;
    else if (pc_latch) pc <= pc + 4;
  end

  // memory: answers mem_lat cycles after seeing the request with A000_0000 + address
  always @(posedge clk) begin
    if (rst) begin
      mem_rvalid <= 0;
      wait_cnt <= 0;
    end else begin
      mem_rvalid <= force_rv;
      if (!mem_req) wait_cnt <= 0;
      else if (mem_on && !mem_rvalid) begin
        if (wait_cnt >= mem_lat) begin
          mem_rvalid <= 1;
          mem_rdata <= 32'hA000_0000 + mem_addr;
          wait_cnt <= 0;
        end else wait_cnt <= wait_cnt + 1;
      end
    end
  end

  // record every decode handshake and every pc latch pulse
  always @(posedge clk) begin
    if (!rst && instr_valid && instr_ready && !flush) acc_q.push_back({instr_pc, instr});
    if (!rst && pc_latch) latch_cnt <= latch_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // accepted words must walk the address space in 4-byte steps with matching data
  task automatic drain_check();
    logic [63:0] e;
    while (acc_q.size() > 0) begin
      e = acc_q.pop_front();
      check("acc_pc", e[63:32], model_pc);
      check("acc_instr", e[31:0], 32'hA000_0000 + model_pc);
      model_pc += 4;
      acc_total++;
    end
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 40 && !instr_valid; i++) step();
    check(tag, instr_valid, 1);
  endtask

  initial begin
    rst = 1;
    step();
    step();
    check("rst_valid", instr_valid, 0);
    check("rst_req", mem_req, 0);
    check("rst_fault", fault, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_latch", pc_latch, 0);
    rst = 0;
    instr_ready = 1;
    step();
    check("idle_to_req", mem_req, 1);
    check("first_addr", mem_addr, 0);
    for (int i = 0; i < 60 && acc_q.size() < 3; i++) step();
    check("first_three", acc_q.size() >= 3, 1);
    drain_check();
    // randomized latency, decode backpressure and flushes
    for (int i = 0; i < 400; i++) begin
      step();
      mem_lat = $urandom_range(0, 3);
      instr_ready = $urandom_range(0, 1);
      flush = $urandom_range(0, 7) == 0;
      #1;
      check("latch_rule", pc_latch, instr_valid && instr_ready && !flush);
      check("no_fault", fault, 0);
    end
    flush = 0;
    instr_ready = 0;
    mem_lat = 0;
    check("rand_progress", acc_q.size() >= 10, 1);
    // backpressure: word held stable, no pc advance
    wait_valid("p2_valid");
    drain_check();
    p = pc;
    v = instr;
    ip = instr_pc;
    check("p2_pc_match", ip, model_pc);
    for (int i = 0; i < 5; i++) begin
      step();
      check("p2_hold_valid", instr_valid, 1);
      check("p2_hold_instr", instr, v);
      check("p2_hold_pc", instr_pc, ip);
      check("p2_no_latch", pc_latch, 0);
      check("p2_pc_stable", pc, p);
    end
    instr_ready = 1;
    #1;
    check("p2_latch", pc_latch, 1);
    step();
    check("p2_pc_adv", pc, p + 4);
    check("p2_valid_drop", instr_valid, 0);
    // flush during a request: drain, drop, refetch the same pc
    mem_lat = 3;
    check("p3_idle", mem_req, 0);
    step();
    check("p3_req", mem_req, 1);
    p = pc;
    flush = 1;
    step();
    flush = 0;
    for (int i = 0; i < 20 && mem_req; i++) begin
      check("p3_no_valid", instr_valid, 0);
      check("p3_addr", mem_addr, p);
      step();
    end
    check("p3_drained", mem_req, 0);
    check("p3_pc", pc, p);
    instr_ready = 0;
    mem_lat = 0;
    wait_valid("p3_refetch");
    check("p3_refetch_pc", instr_pc, p);
    // flush beats a decode accept
    p = instr_pc;
    instr_ready = 1;
    flush = 1;
    #1;
    check("p4_no_latch", pc_latch, 0);
    step();
    flush = 0;
    instr_ready = 0;
    check("p4_valid_drop", instr_valid, 0);
    check("p4_pc", pc, p);
    wait_valid("p4_refetch");
    check("p4_refetch_pc", instr_pc, p);
    // memory never answers: fault after the timeout
    mem_on = 0;
    instr_ready = 1;
    step();
    instr_ready = 0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (fault) break;
      if (mem_req) cnt++;
    end
    check("p5_req_cycles", cnt, 16);
    check("p5_fault", fault, 1);
    check("p5_req_low", mem_req, 0);
    force_rv = 1;
    instr_ready = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("p5_sticky", fault, 1);
      check("p5_ignore_valid", instr_valid, 0);
      check("p5_ignore_req", mem_req, 0);
      check("p5_ignore_latch", pc_latch, 0);
    end
    force_rv = 0;
    instr_ready = 0;
    mem_on = 1;
    drain_check();
    check("latch_count", latch_cnt, acc_total);
    rst = 1;
    step();
    check("p5_rst_fault", fault, 0);
    check("p5_rst_req", mem_req, 0);
    check("p5_rst_valid", instr_valid, 0);
    check("p5_rst_instr", instr, 0);
    // misaligned pc faults straight out of IDLE
    force_en = 1;
    force_val = 32'h0000_0006;
    step();
    rst = 0;
    force_en = 0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (mem_req) cnt++;
      check("p6_fault", fault, 1);
    end
    check("p6_no_req", cnt, 0);
    check("p6_no_valid", instr_valid, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
